// File: rtl/rx_correlator_mac.sv
// ============================================================================
// rx_correlator_mac : time-multiplexed ternary correlator with peak tracker
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx_correlator_mac #(
   parameter int DATA_W = 16,
   parameter int N_TAPS = 20,
   parameter int LANES  = 4,
   parameter int ACC_W  = 21,
   parameter int PTR_W  = 5
) (
   input  logic                       crx_clk,
   input  logic                       rrx_rst,
   input  logic                       erx_en,
   input  logic                       inew_sample_trig,
   input  logic [DATA_W*N_TAPS-1:0]   idata_window,
   input  logic [2*N_TAPS-1:0]        icode,
   input  logic [PTR_W-1:0]           iorder_pointer,
   input  logic                       iclear_peak,
   output logic [ACC_W-1:0]           ocorr_value,
   output logic                       ocorr_valid,
   output logic                       obusy,
   output logic                       ooverrun,
   output logic [ACC_W-1:0]           opeak_mag,
   output logic [15:0]                opeak_index
);

   localparam int STEPS  = N_TAPS / LANES;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int SUM_W  = IDX_W + 1;
   localparam int PW     = (PTR_W > SUM_W) ? PTR_W + 1 : SUM_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [DATA_W*N_TAPS-1:0]   win_q, win_d;
   logic [2*N_TAPS-1:0]        code_q, code_d;
   logic [IDX_W-1:0]           p_q, p_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [STEP_W-1:0]          step_q, step_d;
   logic [ACC_W-1:0]           corr_value_q, corr_value_d;
   logic                       corr_valid_q, corr_valid_d;
   logic                       overrun_q, overrun_d;
   logic [ACC_W-1:0]           peak_mag_q, peak_mag_d;
   logic [15:0]                peak_idx_q, peak_idx_d;
   logic [15:0]                res_cnt_q, res_cnt_d;

   // Pointer folded into 0..N_TAPS-1; legal pointers are below 2*N_TAPS
   logic [PW-1:0]              ptr_ext;
   logic [IDX_W-1:0]           p_norm;

   always_comb begin
      ptr_ext = PW'(iorder_pointer);
      if (ptr_ext >= PW'(N_TAPS)) begin
         ptr_ext = ptr_ext - PW'(N_TAPS);
      end
      p_norm = IDX_W'(ptr_ext);
   end

   logic signed [ACC_W-1:0]    lane_sum;
   logic [SUM_W-1:0]           tap_idx;
   logic [SUM_W-1:0]           smp_idx;
   logic [DATA_W-1:0]          smp;
   logic [1:0]                 cf;
   logic signed [ACC_W-1:0]    smp_ext;

   // Negation happens at ACC_W, so the most negative sample negates exactly
   always_comb begin
      lane_sum = '0;
      tap_idx  = '0;
      smp_idx  = '0;
      smp      = '0;
      cf       = '0;
      smp_ext  = '0;
      for (int l = 0; l < LANES; l++) begin
         tap_idx = SUM_W'(step_q) * SUM_W'(LANES) + SUM_W'(l);
         smp_idx = tap_idx + SUM_W'(p_q);
         if (smp_idx >= SUM_W'(N_TAPS)) begin
            smp_idx = smp_idx - SUM_W'(N_TAPS);
         end
         smp     = win_q[smp_idx*DATA_W +: DATA_W];
         cf      = code_q[tap_idx*2 +: 2];
         smp_ext = ACC_W'($signed(smp));
         if (cf == 2'b01) begin
            lane_sum = lane_sum + smp_ext;
         end else if (cf == 2'b11) begin
            lane_sum = lane_sum - smp_ext;
         end
      end
   end

   logic [ACC_W-1:0]           acc_mag;
   assign acc_mag = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      code_d       = code_q;
      p_d          = p_q;
      acc_d        = acc_q;
      step_d       = step_q;
      corr_value_d = corr_value_q;
      corr_valid_d = 1'b0;
      overrun_d    = 1'b0;
      peak_mag_d   = peak_mag_q;
      peak_idx_d   = peak_idx_q;
      res_cnt_d    = res_cnt_q;

      if (erx_en) begin
         if (inew_sample_trig && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
         end
         // Clear lands before any same-edge peak update below
         if (iclear_peak) begin
            peak_mag_d = '0;
            peak_idx_d = '0;
            res_cnt_d  = '0;
         end

         case (state_q)
            S_IDLE: begin
               if (inew_sample_trig) begin
                  win_d   = idata_window;
                  code_d  = icode;
                  p_d     = p_norm;
                  acc_d   = '0;
                  step_d  = '0;
                  state_d = S_ACCUM;
               end
            end
            S_ACCUM: begin
               acc_d = acc_q + lane_sum;
               if (step_q == STEP_W'(STEPS - 1)) begin
                  step_d  = '0;
                  state_d = S_DONE;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
            S_DONE: begin
               corr_value_d = acc_q;
               corr_valid_d = 1'b1;
               state_d      = S_IDLE;
               if (acc_mag > peak_mag_d) begin
                  peak_mag_d = acc_mag;
                  peak_idx_d = res_cnt_d;
               end
               if (res_cnt_d != 16'hFFFF) begin
                  res_cnt_d = res_cnt_d + 16'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge crx_clk or posedge rrx_rst) begin
      if (rrx_rst) begin
         state_q      <= S_IDLE;
         win_q        <= '0;
         code_q       <= '0;
         p_q          <= '0;
         acc_q        <= '0;
         step_q       <= '0;
         corr_value_q <= '0;
         corr_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         peak_mag_q   <= '0;
         peak_idx_q   <= '0;
         res_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         code_q       <= code_d;
         p_q          <= p_d;
         acc_q        <= acc_d;
         step_q       <= step_d;
         corr_value_q <= corr_value_d;
         corr_valid_q <= corr_valid_d;
         overrun_q    <= overrun_d;
         peak_mag_q   <= peak_mag_d;
         peak_idx_q   <= peak_idx_d;
         res_cnt_q    <= res_cnt_d;
      end
   end

   // Pulses are masked while disabled so a stall never shows a stale pulse
   assign ocorr_valid = corr_valid_q & erx_en;
   assign ooverrun    = overrun_q & erx_en;
   assign obusy       = (state_q != S_IDLE);
   assign ocorr_value = corr_value_q;
   assign opeak_mag   = peak_mag_q;
   assign opeak_index = peak_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_correlator_mac.sv
// ============================================================================
// tb_rx_correlator_mac : randomized and directed bench against a sum-of-products model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rx_correlator_mac;

   localparam int DW = 16;
   localparam int N  = 20;
   localparam int L  = 4;
   localparam int AW = 21;
   localparam int PW = 5;

   logic              crx_clk = 1'b0;
   logic              rrx_rst;
   logic              erx_en;
   logic              trig;
   logic              clr;
   logic [DW*N-1:0]   win;
   logic [2*N-1:0]    code;
   logic [PW-1:0]     ptr;
   logic [AW-1:0]     ocorr_value;
   logic              ocorr_valid;
   logic              obusy;
   logic              ooverrun;
   logic [AW-1:0]     opeak_mag;
   logic [15:0]       opeak_index;

   rx_correlator_mac #(
      .DATA_W(DW), .N_TAPS(N), .LANES(L), .ACC_W(AW), .PTR_W(PW)
   ) dut (
      .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en),
      .inew_sample_trig(trig), .idata_window(win), .icode(code),
      .iorder_pointer(ptr), .iclear_peak(clr), .ocorr_value(ocorr_value),
      .ocorr_valid(ocorr_valid), .obusy(obusy), .ooverrun(ooverrun),
      .opeak_mag(opeak_mag), .opeak_index(opeak_index)
   );

   always #5 crx_clk = ~crx_clk;

   int vectors     = 0;
   int miscompares = 0;
   int s_arr[N];
   int c_arr[N];

   // Correlation straight from the definition: sum of coef[k] * sample[(k+p) mod N]
   function automatic int model(input int p_raw);
      int p;
      int acc;
      p   = (p_raw < N) ? p_raw : p_raw - N;
      acc = 0;
      for (int k = 0; k < N; k++) begin
         if (c_arr[k] == 1)      acc += s_arr[(k + p) % N];
         else if (c_arr[k] == 3) acc -= s_arr[(k + p) % N];
      end
      return acc;
   endfunction

   task automatic drive(input int p);
      for (int k = 0; k < N; k++) begin
         win[k*DW +: DW] = s_arr[k][DW-1:0];
         code[2*k +: 2]  = c_arr[k][1:0];
      end
      ptr = p[PW-1:0];
   endtask

   task automatic fill(input int s, input int c);
      for (int k = 0; k < N; k++) begin
         s_arr[k] = s;
         c_arr[k] = c;
      end
   endtask

   task automatic randomize_arrays();
      logic [15:0] r;
      for (int k = 0; k < N; k++) begin
         r        = 16'($urandom);
         s_arr[k] = int'($signed(r));
         c_arr[k] = int'($urandom_range(0, 3));
      end
   endtask

   task automatic tick();
      @(posedge crx_clk);
      #1;
   endtask

   task automatic fire();
      trig = 1'b1;
      tick();
      trig = 1'b0;
   endtask

   // Waits for ocorr_valid with a bounded budget; lat stays at 40 on timeout
   task automatic wait_valid(output int lat, output int busy_cnt, output int ovr_cnt);
      lat = 0; busy_cnt = 0; ovr_cnt = 0;
      while (lat < 40) begin
         if (obusy) busy_cnt++;
         tick();
         lat++;
         if (ooverrun) ovr_cnt++;
         if (ocorr_valid) break;
      end
   endtask

   task automatic test_reset();
      rrx_rst = 1'b1; erx_en = 1'b1; trig = 1'b0; clr = 1'b0;
      fill(0, 0); drive(0);
      tick(); tick();
      rrx_rst = 1'b0;
      tick();
      vectors++;
      if ({ocorr_value, ocorr_valid, obusy, ooverrun, opeak_mag, opeak_index} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got val=%0d v=%0b b=%0b o=%0b mag=%0d idx=%0d, expected all 0",
                  ocorr_value, ocorr_valid, obusy, ooverrun, opeak_mag, opeak_index);
      end
   endtask

   task automatic test_constant();
      int lat, bc, oc;
      fill(100, 1); drive(0);
      fire();
      wait_valid(lat, bc, oc);
      vectors++;
      if (lat !== 6) begin miscompares++; $display("FAIL const_latency: got %0d expected 6", lat); end
      vectors++;
      if ($signed(ocorr_value) !== 2000) begin
         miscompares++; $display("FAIL const_value: got %0d expected 2000", $signed(ocorr_value));
      end
      vectors++;
      if (bc !== 6 || obusy !== 1'b0) begin
         miscompares++; $display("FAIL const_busy: got %0d busy cycles, busy_at_valid=%0b, expected 6/0", bc, obusy);
      end
   endtask

   task automatic test_rotation();
      int lat, bc, oc;
      int ptrs[3] = '{0, 1, 21};
      int exps[3] = '{-10, 10, 10};
      for (int k = 0; k < N; k++) begin
         s_arr[k] = k;
         c_arr[k] = (k % 2 == 0) ? 1 : 3;
      end
      for (int i = 0; i < 3; i++) begin
         drive(ptrs[i]);
         fire();
         wait_valid(lat, bc, oc);
         vectors++;
         if (lat !== 6 || $signed(ocorr_value) !== exps[i]) begin
            miscompares++;
            $display("FAIL rotation_ptr%0d: got %0d (lat %0d) expected %0d (lat 6)",
                     ptrs[i], $signed(ocorr_value), lat, exps[i]);
         end
      end
   endtask

   task automatic test_min_sample();
      int lat, bc, oc;
      fill(-32768, 3); drive(0);
      fire();
      wait_valid(lat, bc, oc);
      vectors++;
      if ($signed(ocorr_value) !== 655360) begin
         miscompares++; $display("FAIL min_value: got %0d expected 655360", $signed(ocorr_value));
      end
      vectors++;
      if (opeak_mag !== 21'd655360) begin
         miscompares++; $display("FAIL min_peak: got %0d expected 655360", opeak_mag);
      end
   endtask

   task automatic test_overrun();
      int lat, bc, oc, exp_v, ovr;
      randomize_arrays();
      exp_v = model(7);
      drive(7);
      fire();
      tick();
      randomize_arrays(); drive(3);
      fire();
      ovr = ooverrun ? 1 : 0;
      randomize_arrays(); drive(11);
      wait_valid(lat, bc, oc);
      ovr += oc;
      vectors++;
      if (ovr !== 1) begin miscompares++; $display("FAIL overrun_count: got %0d expected 1", ovr); end
      vectors++;
      if (lat + 2 !== 6 || $signed(ocorr_value) !== exp_v) begin
         miscompares++;
         $display("FAIL overrun_result: got %0d at edge %0d expected %0d at edge 6",
                  $signed(ocorr_value), lat + 2, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc, oc, exp_v;
      randomize_arrays(); drive(2);
      fire();
      wait_valid(lat, bc, oc);
      randomize_arrays();
      exp_v = model(30);
      drive(30);
      fire();
      wait_valid(lat, bc, oc);
      vectors++;
      if (lat !== 6 || oc !== 0 || $signed(ocorr_value) !== exp_v) begin
         miscompares++;
         $display("FAIL back_to_back: got %0d lat %0d ovr %0d expected %0d lat 6 ovr 0",
                  $signed(ocorr_value), lat, oc, exp_v);
      end
   endtask

   task automatic test_peak();
      int lat, bc, oc;
      int vals[4] = '{50, -300, 200, 300};
      clr = 1'b1; tick(); clr = 1'b0;
      vectors++;
      if (opeak_mag !== '0 || opeak_index !== 16'd0) begin
         miscompares++; $display("FAIL peak_clear0: got %0d/%0d expected 0/0", opeak_mag, opeak_index);
      end
      for (int i = 0; i < 4; i++) begin
         fill(0, 1); s_arr[0] = vals[i]; drive(0);
         fire();
         wait_valid(lat, bc, oc);
      end
      vectors++;
      if (opeak_mag !== 21'd300 || opeak_index !== 16'd1) begin
         miscompares++; $display("FAIL peak_track: got %0d/%0d expected 300/1", opeak_mag, opeak_index);
      end
      clr = 1'b1; tick(); clr = 1'b0;
      vectors++;
      if (opeak_mag !== '0 || opeak_index !== 16'd0) begin
         miscompares++; $display("FAIL peak_clear1: got %0d/%0d expected 0/0", opeak_mag, opeak_index);
      end
      fill(0, 1); s_arr[0] = 70; drive(0);
      fire();
      repeat (5) tick();
      clr = 1'b1; tick(); clr = 1'b0;
      vectors++;
      if (ocorr_valid !== 1'b1 || opeak_mag !== 21'd70 || opeak_index !== 16'd0) begin
         miscompares++;
         $display("FAIL peak_clear_coincident: got v=%0b %0d/%0d expected v=1 70/0",
                  ocorr_valid, opeak_mag, opeak_index);
      end
      s_arr[0] = -90; drive(0);
      fire();
      wait_valid(lat, bc, oc);
      vectors++;
      if (opeak_mag !== 21'd90 || opeak_index !== 16'd1) begin
         miscompares++; $display("FAIL peak_after_clear: got %0d/%0d expected 90/1", opeak_mag, opeak_index);
      end
   endtask

   task automatic test_stall();
      int lat, bc, oc, exp_v, bad;
      randomize_arrays();
      exp_v = model(19);
      drive(19);
      fire();
      tick(); tick();
      erx_en = 1'b0; trig = 1'b1;
      bad = 0;
      repeat (3) begin
         tick();
         if (ocorr_valid || ooverrun || !obusy) bad++;
      end
      trig = 1'b0; erx_en = 1'b1;
      wait_valid(lat, bc, oc);
      vectors++;
      if (bad !== 0 || oc !== 0) begin
         miscompares++; $display("FAIL stall_hold: got %0d bad stall cycles, %0d overruns, expected 0/0", bad, oc);
      end
      vectors++;
      if (lat + 5 !== 9 || $signed(ocorr_value) !== exp_v) begin
         miscompares++;
         $display("FAIL stall_result: got %0d at edge %0d expected %0d at edge 9",
                  $signed(ocorr_value), lat + 5, exp_v);
      end
   endtask

   task automatic test_random();
      int lat, bc, oc, exp_v, p, best, bi;
      int mags[$];
      clr = 1'b1; tick(); clr = 1'b0;
      for (int r = 0; r < 10; r++) begin
         randomize_arrays();
         p = int'($urandom_range(0, 31));
         exp_v = model(p);
         drive(p);
         fire();
         randomize_arrays(); drive(int'($urandom_range(0, 31)));
         wait_valid(lat, bc, oc);
         mags.push_back(exp_v < 0 ? -exp_v : exp_v);
         best = 0; bi = 0;
         foreach (mags[i]) if (mags[i] > best) begin best = mags[i]; bi = i; end
         vectors++;
         if (lat !== 6 || $signed(ocorr_value) !== exp_v) begin
            miscompares++;
            $display("FAIL random_value%0d: got %0d lat %0d expected %0d lat 6",
                     r, $signed(ocorr_value), lat, exp_v);
         end
         vectors++;
         if (int'(opeak_mag) !== best || int'(opeak_index) !== bi) begin
            miscompares++;
            $display("FAIL random_peak%0d: got %0d/%0d expected %0d/%0d",
                     r, opeak_mag, opeak_index, best, bi);
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      fill(123, 1); drive(0);
      fire();
      tick(); tick(); tick();
      #2 rrx_rst = 1'b1;
      #1;
      vectors++;
      if ({ocorr_value, ocorr_valid, obusy, ooverrun, opeak_mag, opeak_index} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got val=%0d b=%0b mag=%0d idx=%0d expected all 0",
                  ocorr_value, obusy, opeak_mag, opeak_index);
      end
      tick();
      rrx_rst = 1'b0;
      seen = 0;
      repeat (15) begin
         tick();
         if (ocorr_valid || obusy) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++; $display("FAIL reset_mid_no_valid: got %0d active cycles expected 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_rotation();
      test_min_sample();
      test_overrun();
      test_back_to_back();
      test_peak();
      test_stall();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
